// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing defaults and the sideband bundle carried down the pixel pipeline.
package vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic VGA_SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic win;
    logic fs;
  } sideband_t;

  function automatic logic sync_level(input logic active, input logic polarity);
    return active ? polarity : ~polarity;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running h/v raster counters with stage-0 decode of visible, sync, image window and frame start.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter int unsigned IMG_W     = 160,
  parameter int unsigned IMG_H     = 120,
  parameter int unsigned IMG_X0    = 240,
  parameter int unsigned IMG_Y0    = 180,
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW       = $clog2(H_TOTAL),
  localparam int unsigned VW       = $clog2(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output sideband_t     sb_o
);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_START  = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WX_START  = HW'(IMG_X0);
  localparam logic [HW-1:0] WX_END    = HW'(IMG_X0 + IMG_W);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_START  = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WY_START  = VW'(IMG_Y0);
  localparam logic [VW-1:0] WY_END    = VW'(IMG_Y0 + IMG_H);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    sb_o.vis = (h_q < H_VIS_END) && (v_q < V_VIS_END);
    sb_o.hs  = (h_q >= HS_START) && (h_q < HS_END);
    sb_o.vs  = (v_q >= VS_START) && (v_q < VS_END);
    sb_o.win = (h_q >= WX_START) && (h_q < WX_END) && (v_q >= WY_START) && (v_q < WY_END);
    sb_o.fs  = (h_q == '0) && (v_q == '0);
  end

  assign h_o = h_q;
  assign v_o = v_q;

endmodule

// File: rtl/vga_pixel_streamer.sv
// VGA raster source: fetches the stored image from a synchronous frame buffer and emits
// colour with visible/hsync/vsync/frame_start aligned, three cycles behind the raster counters.
module vga_pixel_streamer
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = VGA_H_VISIBLE,
  parameter int unsigned H_FP         = VGA_H_FP,
  parameter int unsigned H_SYNC       = VGA_H_SYNC,
  parameter int unsigned H_BP         = VGA_H_BP,
  parameter int unsigned V_VISIBLE    = VGA_V_VISIBLE,
  parameter int unsigned V_FP         = VGA_V_FP,
  parameter int unsigned V_SYNC       = VGA_V_SYNC,
  parameter int unsigned V_BP         = VGA_V_BP,
  parameter logic        SYNC_ACTIVE  = VGA_SYNC_ACTIVE,
  parameter int unsigned IMG_W        = 160,
  parameter int unsigned IMG_H        = 120,
  parameter int unsigned IMG_X0       = 240,
  parameter int unsigned IMG_Y0       = 180,
  parameter logic [7:0]  BORDER_COLOR = 8'h00,
  parameter int unsigned ADDR_W       = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        pix_color,
  output logic              visible,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  localparam int unsigned HW = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);

  if ((IMG_X0 + IMG_W > H_VISIBLE) || (IMG_Y0 + IMG_H > V_VISIBLE)) begin : g_window_check
    $error("vga_pixel_streamer: image window exceeds the visible area");
  end

  sideband_t         sb0, sb1_q, sb2_q;
  logic [HW-1:0]     h_unused;
  logic [VW-1:0]     v_unused;
  logic [ADDR_W-1:0] addr_base;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        pix_q, pix_d;
  logic              vis_q, hs_q, vs_q, fs_q;

  vga_sync_counter #(
    .H_VISIBLE (H_VISIBLE),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_VISIBLE (V_VISIBLE),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .IMG_X0    (IMG_X0),
    .IMG_Y0    (IMG_Y0)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .h_o    (h_unused),
    .v_o    (v_unused),
    .sb_o   (sb0)
  );

  // Clearing at frame start must still let a corner window use address 0 on the same cycle.
  always_comb begin
    addr_base  = sb0.fs ? '0 : addr_cnt_q;
    addr_cnt_d = addr_base;
    mem_addr_d = mem_addr_q;
    if (sb0.win) begin
      mem_addr_d = addr_base;
      addr_cnt_d = addr_base + ADDR_W'(1);
    end
  end

  // The frame buffer's own output register is the second stage, so mem_rdata lines up with sb2_q.
  always_comb begin
    pix_d = 8'h00;
    if (sb2_q.vis) begin
      pix_d = sb2_q.win ? mem_rdata : BORDER_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb1_q      <= '0;
      sb2_q      <= '0;
      addr_cnt_q <= '0;
      mem_addr_q <= '0;
      pix_q      <= '0;
      vis_q      <= 1'b0;
      hs_q       <= ~SYNC_ACTIVE;
      vs_q       <= ~SYNC_ACTIVE;
      fs_q       <= 1'b0;
    end else begin
      sb1_q      <= sb0;
      sb2_q      <= sb1_q;
      addr_cnt_q <= addr_cnt_d;
      mem_addr_q <= mem_addr_d;
      pix_q      <= pix_d;
      vis_q      <= sb2_q.vis;
      hs_q       <= sync_level(sb2_q.hs, SYNC_ACTIVE);
      vs_q       <= sync_level(sb2_q.vs, SYNC_ACTIVE);
      fs_q       <= sb2_q.fs;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign pix_color   = pix_q;
  assign visible     = vis_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

endmodule

// File: doc/vga_pixel_streamer.md
Name: vga_pixel_streamer

Overview:
Pixel-source end of the colour path into the 8-bit dithering stage. Generates 640x480@60 VGA timing from the pixel clock and fetches a stored grayscale/8-bit-colour image from the frame buffer that the serial receiver fills. Emits a pipelined, sideband-aligned pixel stream of colour, visible, hsync and vsync. The dither stage consumes the colour and visible signals. visible is guaranteed low throughout blanking, so the dither error clears every line.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 1'b0, sync pulse level (0 = active-low)
IMG_W, 160, stored image width
IMG_H, 120, stored image height
IMG_X0, 240, image left column inside the visible area
IMG_Y0, 180, image top line inside the visible area
BORDER_COLOR, 8'h00, colour driven while visible but outside the image window
ADDR_W, $clog2(IMG_W*IMG_H), frame-buffer address width

Ports:
clk  in  1  pixel clock (25.175 MHz nominal)
rst_n  in  1  asynchronous reset, active-low
mem_addr  out  ADDR_W  frame-buffer read address (registered)
mem_rdata  in  8  frame-buffer data, valid one cycle after mem_addr (synchronous BRAM)
pix_color  out  8  pixel colour to the dither stage
visible  out  1  high only while in the active area
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (async assert, sync release): h_cnt = v_cnt = 0; mem_addr = 0; pix_color = 0; visible = 0; frame_start = 0; hsync = vsync = ~SYNC_ACTIVE; all pipeline stages cleared to these values.
- Counters: h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800. On wrap, v_cnt increments over 0..V_TOTAL-1, where V_TOTAL = 525. Both wrap to 0 after (799, 524).
- Stage-0 decode at counter position (h, v):
  - vis0 = h < H_VISIBLE && v < V_VISIBLE
  - hs0 active for H_VISIBLE+H_FP <= h < H_VISIBLE+H_FP+H_SYNC (656..751)
  - vs0 active for lines 490..491
  - win0 = IMG_X0 <= h < IMG_X0+IMG_W && IMG_Y0 <= v < IMG_Y0+IMG_H
  - fs0 = (h == 0 && v == 0)
- Addressing: incrementing address counter, no multiplier.
  - Cleared to 0 when fs0.
  - mem_addr <= addr_cnt on every cycle where win0; addr_cnt then increments.
  - Outside the window, mem_addr holds its value.
  - Result: mem_addr = (v-IMG_Y0)*IMG_W + (h-IMG_X0). The last image pixel gives IMG_W*IMG_H-1.
- Pipeline: total latency 3 cycles from counter position to outputs.
  - Stage 1 registers mem_addr and the sideband (vis, hs, vs, win, fs).
  - Stage 2 captures mem_rdata with the delayed sideband.
  - Stage 3 registers the outputs.
  - hsync, vsync, visible and frame_start are delayed exactly as colour is. No sideband may lead or lag pix_color.
- Output colour:
  - visible && win: mem_rdata.
  - visible && !win: BORDER_COLOR.
  - !visible: 8'h00. This is mandatory so the DAC and dither stage see black in blanking.
- Boundaries:
  - Window may touch the visible edge; elaboration fails if IMG_X0+IMG_W > H_VISIBLE or IMG_Y0+IMG_H > V_VISIBLE.
  - mem_rdata is ignored outside the window.
  - Reset mid-frame restarts at (0,0) with outputs in reset state; the first valid pixel appears 3 cycles after release.
- Single clock domain; no handshake with the frame buffer. Writer arbitration belongs to the dual-port RAM.

Decomposition:
- vga_pkg: H/V timing constants, H_TOTAL/V_TOTAL, sync polarity, and a typedef struct sideband_t {vis, hs, vs, win, fs} used in the pipeline.
- Sub-module vga_sync_counter: h/v counters plus stage-0 decode, producing sideband_t and h/v. Reused by any future overlay block.

Test Plan:
- Reset release, run 2 frames -> hsync low for 96 cycles starting 656+3 cycles after line start; line period 800; vsync low for 2 lines; frame_start period 420000 cycles.
- Memory model returning rdata = addr[7:0] -> output pixel (240,180) = 8'h00; (399,180) = 8'h9F; (240,181) = 8'hA0; (399,299) = 8'hFF (addr 19199).
- BORDER_COLOR = 8'h55 -> pixels (0,0), (239,180) and (639,479) read 8'h55; the next pixel after (639,y) has visible = 0 and pix_color = 8'h00.
- Check every cycle -> visible == 0 whenever pix_color came from the blanking region; visible never high during hsync or vsync.
- Assert rst_n low at h=300, v=200 for 5 cycles -> outputs take reset values immediately (async); after release, frame_start pulses after exactly 3 cycles and mem_addr restarts at 0.
- Window at the corner (IMG_X0 = 0, IMG_Y0 = 0) -> the first visible pixel equals mem[0], and the address wraps to 0 on the next frame.
